// File: rtl/zx_scandoubler.sv
// ZX Spectrum 15 kHz to 31 kHz scandoubler: sync separator, line buffer and doubled-line output timing.
// Optional scanline dimming of the repeated line is enabled by defining ZX_SCANDOUBLER_SCANLINES_EN.
module zx_scandoubler #(
    parameter int LINE_LEN   = 414,
    parameter int VS_THRESH  = 80,
    parameter int H_DE_START = 64,
    parameter int H_DE_END   = 364,
    parameter int V_DE_START = 16,
    parameter int V_DE_END   = 272,
    parameter int HS_START   = 384
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       video,
    input  logic       csync,
    output logic [5:0] video_out,
    output logic       hs_out,
    output logic       vs_out,
    output logic       de_out,
    output logic [7:0] resync_cnt
);

    localparam logic [7:0] VS_T      = 8'(VS_THRESH);
    localparam logic [8:0] SD_LAST   = 9'(LINE_LEN - 1);
    localparam logic [9:0] ZX_LIM    = 10'(2 * LINE_LEN);
    localparam logic [8:0] HDE_START = 9'(H_DE_START);
    localparam logic [8:0] HDE_END   = 9'(H_DE_END);
    localparam logic [9:0] VDE_START = 10'(V_DE_START);
    localparam logic [9:0] VDE_END   = 10'(V_DE_END);
    localparam logic [8:0] HS_COL    = 9'(HS_START);

    typedef enum logic [1:0] {SYNC_HI, SYNC_LO, VSYNC} sync_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    sync_state_t state, next_state;
    logic        cs_d;
    logic [7:0]  sync_len;
    logic [8:0]  sd_col;
    logic [9:0]  zx_col;
    logic [9:0]  line_cnt;
    logic        toggle;
    logic        rise, hs_ev, line_end, vs_enter;
    logic        h_de, v_de, wr_en, pix_bit;
    logic [9:0]  wr_addr, rd_addr;
    logic        rd_pixel_p1;
    logic        line_buf [0:1023];

    assign rise     = csync & ~cs_d;
    assign hs_ev    = rise && (sync_len < VS_T);
    assign line_end = (sd_col == SD_LAST);
    assign vs_enter = (state == SYNC_LO) && !csync && (sync_len == VS_T);
    assign h_de     = (sd_col >= HDE_START) && (sd_col < HDE_END);
    assign v_de     = (line_cnt >= VDE_START) && (line_cnt < VDE_END);
    assign wr_en    = zx_col[0] && (zx_col < ZX_LIM);
    assign wr_addr  = {toggle, zx_col[9:1]};
    assign rd_addr  = {~toggle, sd_col};

    always_comb begin
        next_state = state;
        case (state)
            SYNC_HI: if (!csync) next_state = SYNC_LO;
            SYNC_LO: begin
                if (csync)                   next_state = SYNC_HI;
                else if (sync_len == VS_T)   next_state = VSYNC;
            end
            VSYNC:   if (csync) next_state = SYNC_HI;
            default: next_state = SYNC_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SYNC_HI;
            cs_d       <= 1'b1;
            sync_len   <= 8'd0;
            sd_col     <= 9'd0;
            zx_col     <= 10'd0;
            line_cnt   <= 10'd0;
            toggle     <= 1'b0;
            resync_cnt <= 8'd0;
        end else begin
            state    <= next_state;
            cs_d     <= csync;
            sync_len <= csync ? 8'd0 : sat_inc8(sync_len);
            // A pulse that lands exactly on the natural wrap is already in phase.
            if (hs_ev || line_end) sd_col <= 9'd0;
            else                   sd_col <= sd_col + 9'd1;
            if (hs_ev && !line_end) resync_cnt <= sat_inc8(resync_cnt);
            zx_col <= hs_ev ? 10'd0 : sat_inc10(zx_col);
            if (vs_enter)  line_cnt <= 10'd0;
            else if (rise) line_cnt <= sat_inc10(line_cnt);
            if (rise) toggle <= ~toggle;
        end
    end

    // Stage p1: line buffer write and registered read
    always_ff @(posedge clk) begin
        if (wr_en) line_buf[wr_addr] <= video;
        rd_pixel_p1 <= line_buf[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_out <= 1'b0;
            vs_out <= 1'b0;
            de_out <= 1'b0;
        end else begin
            hs_out <= (sd_col >= HS_COL);
            vs_out <= (next_state == VSYNC);
            de_out <= h_de & v_de;
        end
    end

    assign pix_bit = de_out & ~rd_pixel_p1;

`ifdef ZX_SCANDOUBLER_SCANLINES_EN
    logic rep, rep_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            rep    <= 1'b0;
            rep_p1 <= 1'b0;
        end else begin
            if (hs_ev)         rep <= 1'b0;
            else if (line_end) rep <= 1'b1;
            rep_p1 <= rep;
        end
    end

    assign video_out = rep_p1 ? {1'b0, {5{pix_bit}}} : {6{pix_bit}};
`else
    assign video_out = {6{pix_bit}};
`endif

endmodule

// File: tb/tb_zx_scandoubler.sv
// Directed bench for zx_scandoubler: free-running timing, hsync locking, line doubling, vsync and reset abort.
`timescale 1ns/1ps
module tb_zx_scandoubler;
    logic       clk = 1'b0;
    logic       reset, video, csync;
    logic [5:0] video_out;
    logic       hs_out, vs_out, de_out;
    logic [7:0] resync_cnt;
    int         n_cmp = 0;
    int         n_bad = 0;

`ifdef ZX_SCANDOUBLER_SCANLINES_EN
    localparam logic [5:0] WHITE2 = 6'h1F;
`else
    localparam logic [5:0] WHITE2 = 6'h3F;
`endif

    typedef struct {
        int         cyc;
        int         sd;
        logic       hs;
    } free_vec_t;

    typedef struct {
        int         k;
        logic [5:0] vid;
        logic       hs;
        logic       de;
    } line_vec_t;

    free_vec_t fv [8];
    line_vec_t lv [13];

    zx_scandoubler dut (
        .clk       (clk),
        .reset     (reset),
        .video     (video),
        .csync     (csync),
        .video_out (video_out),
        .hs_out    (hs_out),
        .vs_out    (vs_out),
        .de_out    (de_out),
        .resync_cnt(resync_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One 828-cycle ZX line. Edge k=1 is the line's hsync rise when the previous line had a sync tail.
    task automatic run_line(input bit tail_low, input bit write_pat, input bit chk_tab, input bit chk_lock);
        int idx;
        idx = 0;
        for (int k = 1; k <= 828; k++) begin
            csync = (tail_low && k > 808) ? 1'b0 : 1'b1;
            video = (write_pat && k >= 2) ? (((k - 2) >> 1) % 2 == 0) : 1'b0;
            step();
            if (chk_lock && k == 1) begin
                check("lock sd_col", 32'(dut.sd_col), 0);
                check("lock resync_cnt", 32'(resync_cnt), 1);
            end
            if (chk_tab && idx < 13 && lv[idx].k == k) begin
                check($sformatf("line k=%0d video_out", k), 32'(video_out), 32'(lv[idx].vid));
                check($sformatf("line k=%0d hs_out", k), 32'(hs_out), 32'(lv[idx].hs));
                check($sformatf("line k=%0d de_out", k), 32'(de_out), 32'(lv[idx].de));
                idx++;
            end
        end
    endtask

    initial begin
        int c;
        int blank_bad;

        fv = '{'{1, 1, 1'b0}, '{384, 384, 1'b0}, '{385, 385, 1'b1}, '{413, 413, 1'b1},
               '{414, 0, 1'b1}, '{415, 1, 1'b0}, '{828, 0, 1'b1}, '{829, 1, 1'b0}};

        lv = '{'{65, 6'h00, 1'b0, 1'b0}, '{66, 6'h00, 1'b0, 1'b1}, '{67, 6'h3F, 1'b0, 1'b1},
               '{200, 6'h00, 1'b0, 1'b1}, '{201, 6'h3F, 1'b0, 1'b1}, '{365, 6'h3F, 1'b0, 1'b1},
               '{366, 6'h00, 1'b0, 1'b0}, '{386, 6'h00, 1'b1, 1'b0}, '{415, 6'h00, 1'b1, 1'b0},
               '{416, 6'h00, 1'b0, 1'b0}, '{481, WHITE2, 1'b0, 1'b1}, '{482, 6'h00, 1'b0, 1'b1},
               '{779, WHITE2, 1'b0, 1'b1}};

        reset = 1'b1;
        csync = 1'b1;
        video = 1'b0;
        repeat (3) step();
        check("rst video_out", 32'(video_out), 0);
        check("rst hs_out", 32'(hs_out), 0);
        check("rst vs_out", 32'(vs_out), 0);
        check("rst de_out", 32'(de_out), 0);
        check("rst resync_cnt", 32'(resync_cnt), 0);
        check("rst sd_col", 32'(dut.sd_col), 0);
        reset = 1'b0;

        // Free running with no sync edges
        c = 0;
        for (int i = 0; i < 8; i++) begin
            while (c < fv[i].cyc) begin
                step();
                c++;
            end
            check($sformatf("free c=%0d sd_col", c), 32'(dut.sd_col), 32'(fv[i].sd));
            check($sformatf("free c=%0d hs_out", c), 32'(hs_out), 32'(fv[i].hs));
        end
        check("free resync_cnt", 32'(resync_cnt), 0);

        // Periodic hsync: first pulse corrects phase, later pulses land on the wrap
        for (int n = 1; n <= 17; n++) begin
            if (n == 3) check("pre-lock sd_col", 32'(dut.sd_col), 413);
            run_line(1'b1, 1'b0, 1'b0, n == 3);
            if (n == 2) check("first pulse resync_cnt", 32'(resync_cnt), 1);
        end
        run_line(1'b1, 1'b1, 1'b0, 1'b0);
        check("written line line_cnt", 32'(dut.line_cnt), 17);
        run_line(1'b0, 1'b0, 1'b1, 1'b0);
        check("after lines resync_cnt", 32'(resync_cnt), 1);

        // Vsync: 100 cycles low
        for (int i = 1; i <= 101; i++) begin
            csync = (i <= 100) ? 1'b0 : 1'b1;
            step();
            if (i == 80) begin
                check("vs i=80 vs_out", 32'(vs_out), 0);
                check("vs i=80 line_cnt", 32'(dut.line_cnt), 18);
            end
            if (i == 81) begin
                check("vs i=81 vs_out", 32'(vs_out), 1);
                check("vs i=81 line_cnt", 32'(dut.line_cnt), 0);
            end
            if (i == 100) check("vs i=100 vs_out", 32'(vs_out), 1);
            if (i == 101) begin
                check("vs end vs_out", 32'(vs_out), 0);
                check("vs end line_cnt", 32'(dut.line_cnt), 1);
                check("vs end sd_col", 32'(dut.sd_col), 100);
                check("vs end resync_cnt", 32'(resync_cnt), 1);
            end
        end

        // Outside the vertical window nothing is displayed
        blank_bad = 0;
        for (int k = 0; k < 828; k++) begin
            csync = 1'b1;
            video = 1'b0;
            step();
            if (video_out !== 6'h00 || de_out !== 1'b0) blank_bad++;
        end
        check("vblank nonzero samples", 32'(blank_bad), 0);

        // Reset in the middle of a vsync
        csync = 1'b0;
        repeat (90) step();
        check("pre-reset vs_out", 32'(vs_out), 1);
        reset = 1'b1;
        step();
        check("mid-vsync reset vs_out", 32'(vs_out), 0);
        check("mid-vsync reset resync_cnt", 32'(resync_cnt), 0);
        check("mid-vsync reset line_cnt", 32'(dut.line_cnt), 0);
        check("mid-vsync reset sd_col", 32'(dut.sd_col), 0);
        reset = 1'b0;
        csync = 1'b1;
        repeat (30) step();
        check("post-reset no edge resync_cnt", 32'(resync_cnt), 0);
        csync = 1'b0;
        repeat (20) step();
        csync = 1'b1;
        step();
        check("post-reset hsync resync_cnt", 32'(resync_cnt), 1);
        check("post-reset hsync sd_col", 32'(dut.sd_col), 0);
        check("post-reset hsync vs_out", 32'(vs_out), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/zx_scandoubler.md
ZX_SCANDOUBLER -- requirements
Module: zx_scandoubler

Interface
REQ-001 Parameter LINE_LEN, 414: output line length in clk cycles, 13 MHz domain.
REQ-002 Parameter VS_THRESH, 80: sync-low cycles that qualify a pulse as vsync.
REQ-003 Parameter H_DE_START/H_DE_END, 64/364: output horizontal display window, start inclusive, end exclusive.
REQ-004 Parameter V_DE_START/V_DE_END, 16/272: line_cnt display window, start inclusive, end exclusive.
REQ-005 Parameter HS_START, 384: sd_col at which hs_out asserts; it stays asserted to end of line.
REQ-006 clk  in  1  13 MHz clock, twice the ZX pixel clock. One clock; reset is synchronous and active-high.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 video  in  1  ZX pixel, sampled every second clk; 1 = ink before inversion.
REQ-009 csync  in  1  ZX composite sync, active low.
REQ-010 video_out  out  6  doubled pixel intensity, feeds OSD red/green/blue.
REQ-011 hs_out  out  1  active-high hsync, inverted by the consumer.
REQ-012 vs_out  out  1  active-high vsync.
REQ-013 de_out  out  1  h_de AND v_de.
REQ-014 resync_cnt  out  8  saturating count of hsync phase corrections.

Function
REQ-015 csD SHALL register csync every cycle; rise = csync & ~csD.
REQ-016 Sync separator states: SYNC_HI, SYNC_LO, VSYNC. SYNC_HI→SYNC_LO on csync=0. SYNC_LO→VSYNC when sync_len==VS_THRESH. SYNC_LO/VSYNC→SYNC_HI on csync=1.
REQ-017 sync_len SHALL clear while csync=1, increment while csync=0, and saturate at 255.
REQ-018 vs_out SHALL assert in the cycle after sync_len==VS_THRESH and deassert the cycle after csync returns high; line_cnt SHALL clear at that same VS_THRESH cycle.
REQ-019 An hsync event is rise with sync_len<VS_THRESH.
REQ-020 sd_col (9 bit) SHALL reset to 0 when sd_col==LINE_LEN-1 or on an hsync event; otherwise it increments.
REQ-021 If an hsync event occurs while sd_col!=LINE_LEN-1, resync_cnt SHALL increment, saturating at 255.
REQ-022 If an hsync event and sd_col==LINE_LEN-1 fall in the same cycle, sd_col SHALL make one reset to 0 and resync_cnt SHALL NOT change.
REQ-023 On every rise, including vsync ends, toggle SHALL invert and line_cnt SHALL increment, saturating at 1023.
REQ-024 zx_col (10 bit) SHALL clear on an hsync event, else increment, saturating at 1023.
REQ-025 Line buffer: 2x512 bits. When zx_col[0]=1 and zx_col<2*LINE_LEN, write video at {toggle, zx_col[9:1]}; otherwise no write.
REQ-026 Read {~toggle, sd_col} every cycle; the pixel is registered, so the output lags sd_col by 1 cycle.
REQ-027 Pixel bit = de & ~rd_pixel (inverter); video_out = {6{bit}} (see REQ-037).
REQ-028 hs_out = sd_col>=HS_START; de_out = h_de & v_de; all three are registered and aligned with video_out.
REQ-029 Each ZX line is output twice: two LINE_LEN periods per 828-cycle ZX line.

Reset
REQ-030 On reset: sd_col, zx_col, sync_len, line_cnt, resync_cnt = 0; toggle=0; state=SYNC_HI; csD=1.
REQ-031 On reset: video_out=0, hs_out=0, vs_out=0, de_out=0 in the cycle after reset is sampled.
REQ-032 Line buffer contents are not reset; v_de=0 (line_cnt<16) blanks stale data.
REQ-033 Reset asserted mid-line or mid-vsync SHALL abort the state immediately; the first hsync event after release counts as a resync.

Configuration
REQ-034 Macro ZX_SCANDOUBLER_SCANLINES_EN selects scanline dimming.
REQ-035 With ZX_SCANDOUBLER_SCANLINES_EN defined, the second output of each ZX line SHALL drive video_out = {1'b0, {5{bit}}} (6'h1F for white).
REQ-036 The second output is identified by a rep flag that clears on an hsync event and sets at sd_col==LINE_LEN-1.
REQ-037 With ZX_SCANDOUBLER_SCANLINES_EN undefined, both outputs are 6'h3F for white; the rep flag is absent.

Verification
REQ-038 Reset, then csync=1 with no edges -> sd_col wraps 413→0, hs_out high for sd_col 384..413, resync_cnt=0.
REQ-039 hsync pulse of 20 cycles low every 828 cycles -> resync_cnt=1 after the first pulse, then stays 1.
REQ-040 csync low for 100 cycles -> vs_out high from cycle 81, low 1 cycle after csync rises; line_cnt=0 then 1; sd_col not reset.
REQ-041 Write an alternating 1010 video line, then the next line -> both output passes show the inverted pattern, each pixel 2 clk wide, 1-cycle read latency.
REQ-042 Hsync event coincident with sd_col==413 -> sd_col=0 next cycle, resync_cnt unchanged.
REQ-043 With ZX_SCANDOUBLER_SCANLINES_EN, white paper inside the window -> video_out 6'h3F on the first pass, 6'h1F on the second; line_cnt=10 -> video_out 0.
